// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchronisers, PS2_CLK glitch filter, frame FSM with watchdog, show-ahead byte FIFO.
// Define PS2_PARITY_CHK_EN to require odd parity; otherwise the parity bit is sampled and ignored.
module ps2_rx_fifo #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          PS2_CLK,
  input  logic                          PS2_DAT,
  input  logic                          read_ack,
  output logic                          received,
  output logic [7:0]                    received_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   DEPTH     = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_s, dat_s;
  logic                   fclk, fall;
  logic [FW-1:0]          filt_cnt;
  state_t                 state, state_next;
  logic                   push_now, err_now, parity_ok;
  logic [7:0]             shift;
  logic [2:0]             bit_cnt;
  logic [TW-1:0]          to_cnt;
  logic                   push_req;
  logic [7:0]             push_byte;
  logic [7:0]             mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [AW:0]            level;
  logic                   do_push, do_pop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], PS2_DAT};
    end
  end

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];

  // The filtered clock flips on the FILTER_LEN-th consecutive disagreeing sample;
  // a 1->0 flip raises the one-cycle fall strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fclk     <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s != fclk) begin
        if (filt_cnt == FILT_LAST) begin
          fclk     <= clk_s;
          filt_cnt <= '0;
          fall     <= fclk;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

`ifdef PS2_PARITY_CHK_EN
  logic par_bit;

  always_ff @(posedge clk) begin
    if (!rst)
      par_bit <= 1'b0;
    else if (fall && state == PARITY)
      par_bit <= dat_s;
  end

  assign parity_ok = ^{shift, par_bit};
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // A falling-edge strobe takes priority over the watchdog in the same cycle.
  always_comb begin
    state_next = state;
    push_now   = 1'b0;
    err_now    = 1'b0;
    if (state != IDLE && !fall && to_cnt == TO_LAST) begin
      state_next = IDLE;
      err_now    = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE:   if (!dat_s) state_next = DATA;
        DATA:   if (bit_cnt == 3'd7) state_next = PARITY;
        PARITY: state_next = STOP;
        STOP: begin
          if (dat_s && parity_ok)
            push_now = 1'b1;
          else
            err_now = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shift     <= '0;
      bit_cnt   <= '0;
      to_cnt    <= '0;
      push_req  <= 1'b0;
      push_byte <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err_now;
      push_req  <= push_now;
      if (push_now)
        push_byte <= shift;
      if (fall || state == IDLE)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + 1'b1;
      if (err_now) begin
        shift   <= '0;
        bit_cnt <= '0;
      end else if (fall) begin
        case (state)
          IDLE: begin
            shift   <= '0;
            bit_cnt <= '0;
          end
          DATA: begin
            shift   <= {dat_s, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // A push into a full FIFO still succeeds when a pop frees a slot in the same cycle.
  assign do_pop  = read_ack && (level != '0);
  assign do_push = push_req && ((level != DEPTH) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= push_byte;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push_req && !do_push)
        overflow <= 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign received      = (level != '0);
  assign received_data = received ? mem[rd_ptr] : 8'h00;
  assign fifo_level    = level;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: drives PS/2 frames on the pins and checks the FIFO against a queue model.
// Parity expectations follow PS2_PARITY_CHK_EN when it is defined for the build.
module tb_ps2_rx_fifo;
  localparam int DEPTH = 4;
  localparam int HALF  = 125;
  localparam int TO    = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DAT = 1'b1;
  logic       read_ack = 1'b0;
  logic       received;
  logic [7:0] received_data;
  logic [2:0] fifo_level;
  logic       frame_err;
  logic       overflow;

  int         errors = 0;
  int         checks = 0;
  int         err_seen = 0;
  logic [7:0] exp_q[$];
  logic       exp_ovf = 1'b0;

  ps2_rx_fifo #(
    .SYNC_STAGES(2),
    .FILTER_LEN(8),
    .TIMEOUT_CYCLES(TO),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .PS2_CLK(PS2_CLK),
    .PS2_DAT(PS2_DAT),
    .read_ack(read_ack),
    .received(received),
    .received_data(received_data),
    .fifo_level(fifo_level),
    .frame_err(frame_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (frame_err === 1'b1) err_seen++;

  // Bits go out start, data LSB first, odd parity, stop; the device changes data while PS2_CLK is high.
  // With ack_at_stop the read_ack pulse lands on the cycle the stop-bit byte is pushed.
  task automatic send_frame(input logic [7:0] data, input logic par_flip, input logic stop_bit,
                            input int nbits, input logic ack_at_stop);
    logic [10:0] bits;
    bits = {stop_bit, (~^data) ^ par_flip, data, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      PS2_DAT = bits[i];
      repeat (HALF) @(negedge clk);
      PS2_CLK = 1'b0;
      if (ack_at_stop && i == 10) begin
        repeat (11) @(negedge clk);
        read_ack = 1'b1;
        @(negedge clk);
        read_ack = 1'b0;
        repeat (HALF - 12) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      PS2_CLK = 1'b1;
    end
    if (nbits == 11) begin
      repeat (HALF) @(negedge clk);
      PS2_DAT = 1'b1;
    end
  endtask

  task automatic model_push(input logic [7:0] b);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else exp_ovf = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    exp_ovf = 1'b0;
    checks++; if (received !== 1'b0) begin errors++; $display("[TB] FAIL reset_received got=%b exp=0", received); end
    checks++; if (received_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got=%h exp=00", received_data); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL reset_level got=%0d exp=0", fifo_level); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_single;
    int base;
    base = err_seen;
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    model_push(8'h1C);
    checks++; if (received !== 1'b1) begin errors++; $display("[TB] FAIL single_received got=%b exp=1", received); end
    checks++; if (received_data !== exp_q[0]) begin errors++; $display("[TB] FAIL single_data got=%h exp=%h", received_data, exp_q[0]); end
    checks++; if (fifo_level !== 3'(exp_q.size())) begin errors++; $display("[TB] FAIL single_level got=%0d exp=%0d", fifo_level, exp_q.size()); end
    checks++; if (err_seen !== base) begin errors++; $display("[TB] FAIL single_no_err got=%0d exp=%0d", err_seen, base); end
    read_ack = 1'b1; @(negedge clk); read_ack = 1'b0;
    void'(exp_q.pop_front());
    checks++; if (received !== 1'b0) begin errors++; $display("[TB] FAIL single_drained got=%b exp=0", received); end
  endtask

  task automatic test_in_order;
    logic [7:0] bytes [3];
    logic [7:0] e;
    bytes[0] = 8'h1C; bytes[1] = 8'hF0; bytes[2] = 8'h1C;
    for (int i = 0; i < 3; i++) begin
      send_frame(bytes[i], 1'b0, 1'b1, 11, 1'b0);
      model_push(bytes[i]);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (received_data !== e || received !== 1'b1) begin errors++; $display("[TB] FAIL order_data got=%h/%b exp=%h/1", received_data, received, e); end
      read_ack = 1'b1; @(negedge clk); read_ack = 1'b0;
      checks++; if (fifo_level !== 3'(exp_q.size())) begin errors++; $display("[TB] FAIL order_level got=%0d exp=%0d", fifo_level, exp_q.size()); end
    end
    checks++; if (received !== 1'b0) begin errors++; $display("[TB] FAIL order_empty got=%b exp=0", received); end
    checks++; if (received_data !== 8'h00) begin errors++; $display("[TB] FAIL order_empty_data got=%h exp=00", received_data); end
  endtask

  task automatic test_overflow;
    logic [7:0] bytes [5];
    logic [7:0] e;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44; bytes[4] = 8'h55;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        checks++; if (overflow !== exp_ovf) begin errors++; $display("[TB] FAIL ovf_before got=%b exp=%b", overflow, exp_ovf); end
      end
      send_frame(bytes[i], 1'b0, 1'b1, 11, 1'b0);
      model_push(bytes[i]);
    end
    checks++; if (fifo_level !== 3'(exp_q.size())) begin errors++; $display("[TB] FAIL ovf_level got=%0d exp=%0d", fifo_level, exp_q.size()); end
    checks++; if (overflow !== exp_ovf) begin errors++; $display("[TB] FAIL ovf_flag got=%b exp=%b", overflow, exp_ovf); end
    checks++; if (received_data !== exp_q[0]) begin errors++; $display("[TB] FAIL ovf_head got=%h exp=%h", received_data, exp_q[0]); end
    send_frame(8'h66, 1'b0, 1'b1, 11, 1'b1);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h66);
    checks++; if (fifo_level !== 3'(exp_q.size())) begin errors++; $display("[TB] FAIL ovf_pushpop_level got=%0d exp=%0d", fifo_level, exp_q.size()); end
    checks++; if (overflow !== exp_ovf) begin errors++; $display("[TB] FAIL ovf_pushpop_flag got=%b exp=%b", overflow, exp_ovf); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (received_data !== e) begin errors++; $display("[TB] FAIL ovf_drain got=%h exp=%h", received_data, e); end
      read_ack = 1'b1; @(negedge clk); read_ack = 1'b0;
    end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL ovf_drained got=%0d exp=0", fifo_level); end
  endtask

  task automatic test_frame_errors;
    int base;
    int exp_err;
    base = err_seen;
`ifdef PS2_PARITY_CHK_EN
    exp_err = base + 1;
    send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);
`else
    exp_err = base;
    send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);
    model_push(8'h1C);
`endif
    checks++; if (err_seen !== exp_err) begin errors++; $display("[TB] FAIL parity_err got=%0d exp=%0d", err_seen, exp_err); end
    checks++; if (fifo_level !== 3'(exp_q.size())) begin errors++; $display("[TB] FAIL parity_level got=%0d exp=%0d", fifo_level, exp_q.size()); end
    send_frame(8'h3A, 1'b0, 1'b0, 11, 1'b0);
    exp_err = exp_err + 1;
    checks++; if (err_seen !== exp_err) begin errors++; $display("[TB] FAIL stop_err got=%0d exp=%0d", err_seen, exp_err); end
    checks++; if (fifo_level !== 3'(exp_q.size())) begin errors++; $display("[TB] FAIL stop_level got=%0d exp=%0d", fifo_level, exp_q.size()); end
    while (exp_q.size() > 0) begin
      checks++; if (received_data !== exp_q[0]) begin errors++; $display("[TB] FAIL parity_data got=%h exp=%h", received_data, exp_q[0]); end
      void'(exp_q.pop_front());
      read_ack = 1'b1; @(negedge clk); read_ack = 1'b0;
    end
  endtask

  task automatic test_timeout;
    int base;
    int elapsed;
    logic hit;
    base = err_seen;
    hit = 1'b0;
    elapsed = HALF;
    send_frame(8'hA5, 1'b0, 1'b1, 5, 1'b0);
    for (int c = 0; c < 3000 && !hit; c++) begin
      @(negedge clk);
      elapsed++;
      if (frame_err === 1'b1) hit = 1'b1;
    end
    checks++; if (!hit || elapsed < TO - 10 || elapsed > TO + 40) begin errors++; $display("[TB] FAIL timeout_delay got=%0d hit=%b exp=about %0d", elapsed, hit, TO); end
    @(negedge clk);
    checks++; if (err_seen !== base + 1) begin errors++; $display("[TB] FAIL timeout_pulse got=%0d exp=%0d", err_seen, base + 1); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL timeout_level got=%0d exp=0", fifo_level); end
    send_frame(8'h5A, 1'b0, 1'b1, 11, 1'b0);
    model_push(8'h5A);
    checks++; if (received_data !== exp_q[0] || received !== 1'b1) begin errors++; $display("[TB] FAIL timeout_recover got=%h exp=%h", received_data, exp_q[0]); end
    void'(exp_q.pop_front());
    read_ack = 1'b1; @(negedge clk); read_ack = 1'b0;
  endtask

  task automatic test_glitch_and_reset;
    int base;
    base = err_seen;
    PS2_DAT = 1'b0;
    for (int g = 0; g < 4; g++) begin
      PS2_CLK = 1'b0;
      repeat (3) @(negedge clk);
      PS2_CLK = 1'b1;
      repeat (20) @(negedge clk);
    end
    PS2_DAT = 1'b1;
    send_frame(8'h33, 1'b0, 1'b1, 11, 1'b0);
    model_push(8'h33);
    checks++; if (received_data !== exp_q[0] || fifo_level !== 3'(exp_q.size())) begin errors++; $display("[TB] FAIL glitch_data got=%h/%0d exp=%h/%0d", received_data, fifo_level, exp_q[0], exp_q.size()); end
    checks++; if (err_seen !== base) begin errors++; $display("[TB] FAIL glitch_no_err got=%0d exp=%0d", err_seen, base); end
    send_frame(8'h29, 1'b0, 1'b1, 5, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_q.delete();
    exp_ovf = 1'b0;
    checks++; if (received !== 1'b0 || received_data !== 8'h00) begin errors++; $display("[TB] FAIL midreset_out got=%b/%h exp=0/00", received, received_data); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("[TB] FAIL midreset_level got=%0d exp=0", fifo_level); end
    checks++; if (overflow !== exp_ovf) begin errors++; $display("[TB] FAIL midreset_ovf got=%b exp=%b", overflow, exp_ovf); end
    repeat (50) @(negedge clk);
    send_frame(8'h29, 1'b0, 1'b1, 11, 1'b0);
    model_push(8'h29);
    checks++; if (received_data !== exp_q[0] || received !== 1'b1) begin errors++; $display("[TB] FAIL midreset_next got=%h exp=%h", received_data, exp_q[0]); end
    checks++; if (fifo_level !== 3'(exp_q.size())) begin errors++; $display("[TB] FAIL midreset_next_level got=%0d exp=%0d", fifo_level, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_in_order();
    test_overflow();
    test_frame_errors();
    test_timeout();
    test_glitch_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
